// File: rtl/mem_dump_tx_pkg.sv
// Shared constants and FSM encoding for the memory dump serial transmitter.
// Build option: define DUMP_PARITY_EN to add an even-parity bit to every byte frame.
package mem_dump_tx_pkg;

  localparam int unsigned BYTES_PER_WORD       = 4;
  localparam int unsigned FRAME_BITS_NO_PARITY = 10;
  localparam int unsigned FRAME_BITS_PARITY    = 11;

`ifdef DUMP_PARITY_EN
  localparam int unsigned FRAME_BITS = FRAME_BITS_PARITY;
`else
  localparam int unsigned FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ       = 3'd1,
    LOAD       = 3'd2,
    START_BIT  = 3'd3,
    DATA_BITS  = 3'd4,
`ifdef DUMP_PARITY_EN
    PARITY_BIT = 3'd5,
`endif
    STOP_BIT   = 3'd6,
    DONE       = 3'd7
  } state_e;

endpackage

// File: rtl/mem_dump_tx_if.sv
// Read-port bundle between the dump engine (master) and the data memory (slave).
interface mem_dump_tx_if;

  logic [31:0] mem_address;
  logic        mem_oe;
  logic [31:0] mem_data;

  modport master (output mem_address, output mem_oe, input mem_data);
  modport slave  (input mem_address, input mem_oe, output mem_data);

endinterface

// File: rtl/baud_gen.sv
// Bit-period timer: while enabled, bitTick fires on the last cycle of every CLKS_PER_BIT period.
module baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic bitTick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cntQ;

  // Held at the reload value while idle so the first bit gets a full period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cntQ <= '0;
    end else if (!enable || (cntQ == '0)) begin
      cntQ <= Reload;
    end else begin
      cntQ <= cntQ - CntW'(1);
    end
  end

  assign bitTick = enable && (cntQ == '0);

endmodule

// File: rtl/mem_dump_tx.sv
// Reads word_count words from memory and streams them LSB-first as UART byte frames on tx.
// Build option: DUMP_PARITY_EN inserts an even-parity bit before the stop bit.
module mem_dump_tx
  import mem_dump_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          base_address,
  input  logic [15:0]          word_count,
  mem_dump_tx_if.master        mem,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

  state_e      stateQ, stateD;
  logic [31:0] addrQ, addrD;
  logic [31:0] shiftQ, shiftD;
  logic [15:0] remainQ, remainD;
  logic [1:0]  byteIdxQ, byteIdxD;
  logic [2:0]  bitIdxQ, bitIdxD;
  logic        bitTick, baudEn;

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clock  (clock),
    .reset  (reset),
    .enable (baudEn),
    .bitTick(bitTick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ   <= IDLE;
      addrQ    <= '0;
      shiftQ   <= '0;
      remainQ  <= '0;
      byteIdxQ <= '0;
      bitIdxQ  <= '0;
    end else begin
      stateQ   <= stateD;
      addrQ    <= addrD;
      shiftQ   <= shiftD;
      remainQ  <= remainD;
      byteIdxQ <= byteIdxD;
      bitIdxQ  <= bitIdxD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    addrD    = addrQ;
    shiftD   = shiftQ;
    remainD  = remainQ;
    byteIdxD = byteIdxQ;
    bitIdxD  = bitIdxQ;
    case (stateQ)
      IDLE: begin
        if (start) begin
          addrD   = base_address;
          remainD = word_count;
          stateD  = (word_count == 16'd0) ? DONE : READ;
        end
      end
      READ: stateD = LOAD;
      LOAD: begin
        shiftD   = mem.mem_data;
        byteIdxD = '0;
        bitIdxD  = '0;
        stateD   = START_BIT;
      end
      START_BIT: begin
        if (bitTick) begin
          bitIdxD = '0;
          stateD  = DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (bitTick) begin
          if (bitIdxQ == 3'd7) begin
`ifdef DUMP_PARITY_EN
            stateD = PARITY_BIT;
`else
            stateD = STOP_BIT;
`endif
          end else begin
            bitIdxD = bitIdxQ + 3'd1;
          end
        end
      end
`ifdef DUMP_PARITY_EN
      PARITY_BIT: begin
        if (bitTick) stateD = STOP_BIT;
      end
`endif
      STOP_BIT: begin
        if (bitTick) begin
          if (byteIdxQ == LastByte) begin
            addrD   = addrQ + 32'd1;
            remainD = remainQ - 16'd1;
            stateD  = (remainQ == 16'd1) ? DONE : READ;
          end else begin
            // Next byte moves into the low lane; no idle gap between bytes of a word.
            byteIdxD = byteIdxQ + 2'd1;
            shiftD   = {8'h00, shiftQ[31:8]};
            stateD   = START_BIT;
          end
        end
      end
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (stateQ)
      START_BIT: tx = 1'b0;
      DATA_BITS: tx = shiftQ[bitIdxQ];
`ifdef DUMP_PARITY_EN
      PARITY_BIT: tx = ^shiftQ[7:0];
`endif
      default:   tx = 1'b1;
    endcase
  end

  assign baudEn          = (stateQ == START_BIT) || (stateQ == DATA_BITS) ||
`ifdef DUMP_PARITY_EN
                           (stateQ == PARITY_BIT) ||
`endif
                           (stateQ == STOP_BIT);
  assign busy            = (stateQ != IDLE) && (stateQ != DONE);
  assign done            = (stateQ == DONE);
  assign mem.mem_oe      = (stateQ == READ);
  assign mem.mem_address = addrQ;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx at CLKS_PER_BIT=4 with a one-cycle-latency memory model.
`timescale 1ns/1ps
module tb_mem_dump_tx;

  localparam int unsigned P = 4;
`ifdef DUMP_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_address = '0;
  logic [15:0] word_count = '0;
  logic        tx, busy, done;
  logic [3:0]  st;
  int          checks = 0;
  int          errors = 0;

  mem_dump_tx_if memBus ();

  mem_dump_tx #(
    .CLKS_PER_BIT(P)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_address(base_address),
    .word_count  (word_count),
    .mem         (memBus),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // {tx, busy, done, mem_oe}
  assign st = {tx, busy, done, memBus.mem_oe};

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hA5C3_0F81;
      32'hFFFF_FFFF: return 32'h1234_5678;
      32'h0000_0010: return 32'hCAFE_0042;
      default:       return 32'hDEAD_0000 ^ a;
    endcase
  endfunction

  always @(posedge clock) begin
    if (memBus.mem_oe) memBus.mem_data <= mem_lookup(memBus.mem_address);
  end

  task automatic start_dump(input logic [31:0] b, input logic [15:0] n);
    base_address = b;
    word_count   = n;
    start        = 1'b1;
    @(negedge clock);
    start        = 1'b0;
  endtask

  // Entered on the negedge of the first start-bit cycle; leaves one cycle past the stop bit.
  task automatic check_frame(input logic [7:0] b, input string name, input bit poke);
    logic [10:0] bits;
    logic [3:0]  want;
    logic [3:0]  gotFirst;
    logic [3:0]  wantFirst;
    int          bad;
    int          badAt;
`ifdef DUMP_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, 1'b1, b, 1'b0};
`endif
    bad = 0;
    badAt = -1;
    gotFirst = '0;
    wantFirst = '0;
    for (int c = 0; c < FrameBits * int'(P); c++) begin
      want = {bits[c / int'(P)], 1'b1, 1'b0, 1'b0};
      if (st !== want) begin
        if (bad == 0) begin
          badAt = c;
          gotFirst = st;
          wantFirst = want;
        end
        bad++;
      end
      if (poke && c == 5) begin
        start = 1'b1;
        base_address = 32'h0;
        word_count = 16'd7;
      end
      if (poke && c == 6) start = 1'b0;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bad samples, first at cycle %0d got st=%b want st=%b",
               name, bad, badAt, gotFirst, wantFirst);
    end
  endtask

  // Entered on the negedge of the READ cycle.
  task automatic run_word(input logic [31:0] addr, input logic [31:0] w, input string name,
                          input bit poke);
    checks++;
    if (st !== 4'b1101 || memBus.mem_address !== addr) begin
      errors++;
      $display("FAIL %s_read: got st=%b addr=%h want st=1101 addr=%h", name, st,
               memBus.mem_address, addr);
    end
    @(negedge clock);
    checks++;
    if (st !== 4'b1100) begin
      errors++;
      $display("FAIL %s_load: got st=%b want st=1100", name, st);
    end
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      check_frame(w[8*k +: 8], $sformatf("%s_byte%0d", name, k), poke && (k == 1));
    end
  endtask

  task automatic check_done(input string name);
    checks++;
    if (st !== 4'b1010) begin
      errors++;
      $display("FAIL %s_done: got st=%b want st=1010", name, st);
    end
    @(negedge clock);
    checks++;
    if (st !== 4'b1000) begin
      errors++;
      $display("FAIL %s_after_done: got st=%b want st=1000", name, st);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (st !== 4'b1000 || memBus.mem_address !== 32'h0) begin
        errors++;
        $display("FAIL reset_cycle%0d: got st=%b addr=%h want st=1000 addr=0", i, st,
                 memBus.mem_address);
      end
      @(negedge clock);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (st !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release: got st=%b want st=1000", st);
    end
  endtask

  task automatic test_single_word();
    start_dump(32'h0, 16'd1);
    run_word(32'h0, 32'hA5C3_0F81, "single", 1'b0);
    check_done("single");
  endtask

  task automatic test_zero_count();
    start_dump(32'h0, 16'd0);
    check_done("zero");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (st !== 4'b1000) begin
        errors++;
        $display("FAIL zero_idle%0d: got st=%b want st=1000", i, st);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_wrap();
    start_dump(32'hFFFF_FFFF, 16'd2);
    run_word(32'hFFFF_FFFF, 32'h1234_5678, "wrap0", 1'b0);
    run_word(32'h0000_0000, 32'hA5C3_0F81, "wrap1", 1'b0);
    check_done("wrap");
    checks++;
    if (memBus.mem_address !== 32'h1) begin
      errors++;
      $display("FAIL wrap_final_addr: got %h want 00000001", memBus.mem_address);
    end
  endtask

  task automatic test_busy_start();
    start_dump(32'h10, 16'd1);
    run_word(32'h10, 32'hCAFE_0042, "busy", 1'b1);
    check_done("busy");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (st !== 4'b1000 || memBus.mem_address !== 32'h11) begin
        errors++;
        $display("FAIL busy_idle%0d: got st=%b addr=%h want st=1000 addr=00000011", i, st,
                 memBus.mem_address);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid();
    start_dump(32'h10, 16'd1);
    @(negedge clock);
    @(negedge clock);
    check_frame(8'h42, "rstmid_byte0", 1'b0);
    // Byte 1 is 0x00: cycle 25 of its frame sits inside data bit 5.
    repeat (25) @(negedge clock);
    checks++;
    if (st !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_pre: got st=%b want st=0100", st);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (st !== 4'b1000 || memBus.mem_address !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async: got st=%b addr=%h want st=1000 addr=0", st,
               memBus.mem_address);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (st !== 4'b1000) begin
        errors++;
        $display("FAIL rstmid_idle%0d: got st=%b want st=1000", i, st);
      end
    end
    start_dump(32'h0, 16'd1);
    run_word(32'h0, 32'hA5C3_0F81, "rstmid_again", 1'b0);
    check_done("rstmid_again");
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_single_word();
    test_zero_count();
    test_wrap();
    test_busy_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
